// File: rtl/io_signature_harness_pkg.sv
// Shared types, polynomial constant and the 16-bit shift/feedback step
// used by both the stimulus LFSR and the signature MISR.
package io_signature_harness_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESET_DUT = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Taps at bits 15, 13, 12, 10 for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] POLY_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] step16(input logic [15:0] s);
        return {s[14:0], ^(s & POLY_TAPS)};
    endfunction

endpackage

// File: rtl/io_signature_harness_if.sv
// Pin-side bus between the self-test harness (master) and the user core (slave).
interface io_signature_harness_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             dut_rst_n;
    logic             dut_ena;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic [OUT_W-1:0] dut_oe;

    modport master (
        output dut_rst_n,
        output dut_ena,
        output dut_in,
        input  dut_out,
        input  dut_oe
    );

    modport slave (
        input  dut_rst_n,
        input  dut_ena,
        input  dut_in,
        output dut_out,
        output dut_oe
    );
endinterface

// File: rtl/io_signature_harness_lfsr16.sv
// 16-bit shift register with load, step-enable and parallel xor-in:
// xor_i tied to zero gives a plain LFSR, driven by data gives a MISR.
module lfsr16
    import io_signature_harness_pkg::*;
#(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        en_i,
    input  logic [15:0] xor_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next value: load has priority over stepping
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (en_i) begin
            q_d = step16(q_q) ^ xor_i;
        end else begin
            q_d = q_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/io_signature_harness.sv
// BIST harness: resets the core, drives LFSR stimulus, compacts outputs into a MISR.
// Define HARNESS_OE_MASK_EN to mask observed outputs with the core's output enables.
module io_signature_harness
    import io_signature_harness_pkg::*;
#(
    parameter int          IN_W       = 8,
    parameter int          OUT_W      = 16,
    parameter int          CYCLES     = 256,
    parameter int          RST_CYCLES = 4,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             exp_sig,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             signature,
    io_signature_harness_if.master  core
);

    localparam int CNT_MAX = (CYCLES > RST_CYCLES) ? CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             init_s;
    logic             run_s;
    logic [15:0]      lfsr_val_s;
    logic [15:0]      misr_val_s;
    logic [15:0]      obs_s;

    logic             busy_s;
    logic             done_s;
    logic             dut_rst_n_s;
    logic             dut_ena_s;
    logic [IN_W-1:0]  dut_in_s;

`ifdef HARNESS_OE_MASK_EN
    assign obs_s = 16'(core.dut_out & core.dut_oe);
`else
    logic unused_oe_s;
    assign unused_oe_s = ^core.dut_oe;
    assign obs_s       = 16'(core.dut_out);
`endif

    // Phase sequencing and the shared phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_s  = 1'b0;
        run_s   = 1'b0;
        case (state_q)
            IDLE: begin
                init_s = 1'b1;
                cnt_d  = '0;
                if (start) begin
                    state_d = RESET_DUT;
                end else begin
                    state_d = IDLE;
                end
            end
            RESET_DUT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (cnt_q == RUN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    init_s  = 1'b1;
                    state_d = RESET_DUT;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status and core-side pin decode from the registered state
    always_comb begin
        busy_s      = 1'b0;
        done_s      = 1'b0;
        dut_rst_n_s = 1'b0;
        dut_ena_s   = 1'b0;
        dut_in_s    = '0;
        case (state_q)
            IDLE: begin
                busy_s = 1'b0;
            end
            RESET_DUT: begin
                busy_s    = 1'b1;
                dut_ena_s = 1'b1;
            end
            RUN: begin
                busy_s      = 1'b1;
                dut_rst_n_s = 1'b1;
                dut_ena_s   = 1'b1;
                dut_in_s    = IN_W'(lfsr_val_s);
            end
            DONE: begin
                done_s      = 1'b1;
                dut_rst_n_s = 1'b1;
                dut_ena_s   = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    lfsr16 #(
        .RST_VAL (SEED)
    ) u_stim (
        .clk        (clk),
        .rst        (rst),
        .load_i     (init_s),
        .load_val_i (SEED),
        .en_i       (run_s),
        .xor_i      (16'h0000),
        .q_o        (lfsr_val_s)
    );

    lfsr16 #(
        .RST_VAL (16'h0000)
    ) u_misr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (init_s),
        .load_val_i (16'h0000),
        .en_i       (run_s),
        .xor_i      (obs_s),
        .q_o        (misr_val_s)
    );

    assign busy           = busy_s;
    assign done           = done_s;
    assign signature      = misr_val_s;
    assign pass           = done_s & (misr_val_s == exp_sig);
    assign core.dut_rst_n = dut_rst_n_s;
    assign core.dut_ena   = dut_ena_s;
    assign core.dut_in    = dut_in_s;

endmodule

// File: tb/tb_io_signature_harness.sv
// Scoreboard bench for io_signature_harness: stimulus pushes expected results,
// a monitor pops and compares on each rising edge of done.
module tb_io_signature_harness;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic [15:0] exp_sig;
    logic [15:0] exp_sig2;
    logic        busy, done, pass;
    logic        busy2, done2, pass2;
    logic [15:0] signature, signature2;
    int          core_mode;
    int          cyc = 0;
    int          tests_run = 0;
    int          fails = 0;
    exp_t        sb_q[$];
    logic        done_prev;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    io_signature_harness_if #(.IN_W(8), .OUT_W(16)) bus ();
    io_signature_harness_if #(.IN_W(8), .OUT_W(16)) bus2 ();

    // Behavioural stand-in for the user core
    always_comb begin
        case (core_mode)
            0:       bus.dut_out = 16'h0000;
            1:       bus.dut_out = 16'h0001;
            default: bus.dut_out = {bus.dut_in, ~bus.dut_in};
        endcase
    end
    assign bus.dut_oe   = 16'hFFFF;
    assign bus2.dut_out = 16'hFFFF;
    assign bus2.dut_oe  = 16'h00FF;

    io_signature_harness #(
        .IN_W(8), .OUT_W(16), .CYCLES(256), .RST_CYCLES(4), .SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .exp_sig(exp_sig),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .core(bus)
    );

    io_signature_harness #(
        .IN_W(8), .OUT_W(16), .CYCLES(1), .RST_CYCLES(4), .SEED(16'hACE1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .exp_sig(exp_sig2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(signature2),
        .core(bus2)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] core_model(input int mode, input logic [7:0] din);
        case (mode)
            0:       return 16'h0000;
            1:       return 16'h0001;
            default: return {din, ~din};
        endcase
    endfunction

    function automatic logic [15:0] ref_sig(input int mode);
        logic [15:0] l;
        logic [15:0] m;
        l = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            m = ref_step(m) ^ core_model(mode, l[7:0]);
            l = ref_step(l);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start-sampling edge
    task automatic issue(input int mode, input logic [15:0] es, input bit scored);
        exp_t e;
        core_mode  = mode;
        exp_sig    = es;
        e.sig      = ref_sig(mode);
        e.pass     = (e.sig == es);
        e.done_cyc = cyc + 261;
        if (scored) sb_q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            tests_run++;
            fails++;
            $display("FAIL done_timeout: %0d results still pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: compare on each rising edge of done
    initial begin
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !done_prev) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_done: at cycle %0d with no pending test", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("signature", 32'(signature), 32'(e.sig));
                    check("pass", 32'(pass), 32'(e.pass));
                    check("done_cycle", cyc, e.done_cyc);
                end
            end
            done_prev = (done === 1'b1);
        end
    end

    initial begin
        logic [15:0] sig2;
        logic [15:0] exp2;
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        exp_sig   = 16'h0000;
`ifdef HARNESS_OE_MASK_EN
        exp2 = 16'h00FF;
`else
        exp2 = 16'hFFFF;
`endif
        exp_sig2  = exp2;
        core_mode = 0;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_signature", 32'(signature), 32'd0);
        check("rst_dut_rst_n", 32'(bus.dut_rst_n), 32'd0);
        check("rst_dut_ena", 32'(bus.dut_ena), 32'd0);
        check("rst_dut_in", 32'(bus.dut_in), 32'd0);

        // rst and start together: rst wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Zero core with stimulus sequence check
        issue(0, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("rstphase_dut_rst_n", 32'(bus.dut_rst_n), 32'd0);
            check("rstphase_busy", 32'(busy), 32'd1);
            check("rstphase_dut_in", 32'(bus.dut_in), 32'd0);
            @(negedge clk);
        end
        check("run1_dut_rst_n", 32'(bus.dut_rst_n), 32'd1);
        check("run1_dut_in", 32'(bus.dut_in), 32'hE1);
        @(negedge clk);
        check("run2_dut_in", 32'(bus.dut_in), 32'hC3);
        drain();

        // Mismatch: constant 1 observed, expected zero
        issue(1, 16'h0000, 1'b1);
        drain();
        check("mismatch_sig_nonzero", 32'(signature != 16'h0000), 32'd1);

        // Data-dependent core, matching expected; start pulses while busy
        issue(2, ref_sig(2), 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Restart directly from DONE, expected off by one bit
        issue(2, ref_sig(2) ^ 16'h0001, 1'b1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_signature", 32'(signature), 32'd0);
        drain();

        // Abort in RUN cycle 10
        issue(2, 16'h0000, 1'b0);
        repeat (13) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_signature", 32'(signature), 32'd0);
        check("abort_dut_ena", 32'(bus.dut_ena), 32'd0);
        repeat (3) @(negedge clk);
        issue(0, 16'h0000, 1'b1);
        drain();

        // Output-enable masking on the CYCLES=1 instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20 && done2 !== 1'b1; i++) @(negedge clk);
        sig2 = signature2;
        check("oe_done", 32'(done2), 32'd1);
        check("oe_signature", 32'(sig2), 32'(exp2));
        check("oe_pass", 32'(pass2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
